alu_issue_stage: RTL and testbench

- Upstream issue stage for the combinational ALU.
- Buffers {op, a, b} commands in a FIFO and presents the head entry to the ALU operand ports.
- Captures the ALU result into a registered valid/ready output stage.
- Decouples bursty command producers from result consumers at 1 command/cycle throughput.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 72 +++++++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode width, opcode
// enumeration and the legality check applied when a result is captured.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    // Opcodes above OP_XOR have no ALU function; the ALU returns 0 for them.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage: DEPTH entries of {op, a, b},
// wrap-around pointers, occupancy count and synchronous flush.
// The command struct is declared here because its width follows WIDTH;
// commands cross the port boundary as flat vectors.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [OP_W+2*WIDTH-1:0]       wr_data,
    input  logic                          rd_en,
    output logic [OP_W+2*WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full
);

    localparam int CMD_W = OP_W + 2 * WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_cmd_t;

    alu_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // A full FIFO refuses pushes even when popping; flush discards both sides.
    assign full    = (count == CNT_W'(DEPTH));
    assign push    = wr_en && !full && !flush;
    assign pop     = rd_en && (count != '0) && !flush;
    assign rd_data = CMD_W'(mem[rd_ptr]);

    // Storage write: data path only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= alu_cmd_t'(wr_data);
        end
    end

    // Pointer and occupancy update; rst takes priority over flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers {op, a, b} commands, presents the FIFO head to
// the combinational ALU and captures its result into a valid/ready output
// register. Optional statistics counters are enabled by ALU_ISSUE_STATS_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [OP_W-1:0]          alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [OP_W-1:0]          out_op,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]              issued_cnt,
    output logic [15:0]              illegal_cnt
`endif
);

    localparam int CMD_W = OP_W + 2 * WIDTH;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_cmd_t;

    alu_cmd_t           cmd_in;
    logic [CMD_W-1:0]   head_raw;
    alu_cmd_t           head_p0;
    logic               full;
    logic               vld_p0;
    logic               load;

    logic               vld_p1;
    logic [WIDTH-1:0]   result_p1;
    logic [OP_W-1:0]    op_p1;
    logic               err_p1;

    assign cmd_in = '{op: in_op, a: in_a, b: in_b};

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (in_valid),
        .wr_data (CMD_W'(cmd_in)),
        .rd_en   (load),
        .rd_data (head_raw),
        .count   (count),
        .full    (full)
    );

    // ---- stage p0: FIFO head drives the ALU operands ----
    assign head_p0  = alu_cmd_t'(head_raw);
    assign vld_p0   = (count != '0);
    assign in_ready = !full;

    // Operands are zeroed when the FIFO is empty so the ALU sees a quiet bus.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (vld_p0) begin
            alu_op = head_p0.op;
            alu_a  = head_p0.a;
            alu_b  = head_p0.b;
        end
    end

    // Capture when a head exists and the output slot is free or draining.
    assign load = vld_p0 && (!vld_p1 || out_ready) && !flush;

    // ---- stage p1: registered result, valid/ready handshake ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            op_p1     <= '0;
            err_p1    <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1    <= 1'b1;
            result_p1 <= alu_result;
            op_p1     <= head_p0.op;
            err_p1    <= !is_legal_op(head_p0.op);
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_result = result_p1;
    assign out_op     = op_p1;
    assign out_err    = err_p1;

`ifdef ALU_ISSUE_STATS_EN
    // Saturating increment: counters stick at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Issue statistics survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (load) begin
            issued_cnt <= sat_inc(issued_cnt);
            if (!is_legal_op(head_p0.op)) begin
                illegal_cnt <= sat_inc(illegal_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic             out_err;
    logic [2:0]       count;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]      issued_cnt;
    logic [15:0]      illegal_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_err    (out_err),
        .count      (count)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .illegal_cnt(illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    logic [2:0] b_op  [5];
    logic [7:0] b_a   [5];
    logic [7:0] b_b   [5];
    logic [7:0] b_exp [5];

    initial begin
        b_op[0] = 3'b001; b_a[0] = 8'h05; b_b[0] = 8'h07; b_exp[0] = 8'hFE;
        b_op[1] = 3'b010; b_a[1] = 8'hF0; b_b[1] = 8'h3C; b_exp[1] = 8'h30;
        b_op[2] = 3'b011; b_a[2] = 8'h0A; b_b[2] = 8'h50; b_exp[2] = 8'h5A;
        b_op[3] = 3'b100; b_a[3] = 8'hFF; b_b[3] = 8'h0F; b_exp[3] = 8'hF0;
        b_op[4] = 3'b000; b_a[4] = 8'hFF; b_b[4] = 8'h01; b_exp[4] = 8'h00;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);

        // Reset then idle
        step(); step();
        rst = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_err", out_err, 0);

        // Single command: 0F + 01
        drive(1'b1, 3'b000, 8'h0F, 8'h01);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("single_alu_a", alu_a, 8'h0F);
        check("single_vld_early", out_valid, 0);
        step();
        check("single_vld", out_valid, 1);
        check("single_result", out_result, 8'h10);
        check("single_err", out_err, 0);
        check("single_count", count, 0);
        step();
        check("single_vld_drop", out_valid, 0);

        // Back-to-back burst with pointer wrap
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, b_op[i], b_a[i], b_b[i]);
            else       drive(1'b0, 3'b000, 8'h00, 8'h00);
            step();
            if (i >= 1) begin
                check($sformatf("burst_vld%0d", i - 1), out_valid, 1);
                check($sformatf("burst_res%0d", i - 1), out_result, b_exp[i - 1]);
                check($sformatf("burst_op%0d", i - 1), out_op, b_op[i - 1]);
            end
        end
        step();
        check("burst_vld_drop", out_valid, 0);

        // Backpressure until full, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'b000, 8'(i), 8'h10);
            step();
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_vld", out_valid, 1);
        check("full_held", out_result, 8'h10);
        step();
        check("full_hold_stable", out_result, 8'h10);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("drain_vld%0d", i), out_valid, 1);
            check($sformatf("drain_res%0d", i), out_result, 8'h10 + 8'(i));
        end
        step();
        check("drain_vld_drop", out_valid, 0);
        check("drain_count", count, 0);

        // Illegal opcode
        drive(1'b1, 3'b110, 8'h12, 8'h34);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        check("ill_vld", out_valid, 1);
        check("ill_result", out_result, 0);
        check("ill_err", out_err, 1);
        check("ill_op", out_op, 3'b110);
`ifdef ALU_ISSUE_STATS_EN
        check("ill_issued", issued_cnt, 12);
        check("ill_illegal", illegal_cnt, 1);
`endif
        step();

        // Flush mid-stream with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, 8'h20, 8'(i));
            step();
        end
        check("pre_flush_count", count, 3);
        check("pre_flush_vld", out_valid, 1);
        flush = 1'b1;
        drive(1'b1, 3'b011, 8'hAA, 8'h55);
        step();
        flush = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("flush_count", count, 0);
        check("flush_vld", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        step();
        check("flush_push_absent", count, 0);
        check("flush_vld_stays", out_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
        check("flush_issued", issued_cnt, 13);
        check("flush_illegal", illegal_cnt, 1);
`endif

        // Recovery after flush
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'h01, 8'h02);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        check("recover_vld", out_valid, 1);
        check("recover_res", out_result, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
